alu_operand_stage: RTL

//  Registered, parametrised ALU operand selector for the multi-cycle datapath.

---
 rtl/alu_operand_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Selects ALU operand A and operand B from the datapath sources and holds
//   each selected pair in a 2-entry skid buffer. The buffer talks to the ALU
//   over a valid/ready handshake, so a stalled ALU never loses a pair.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   flush               synchronous discard of every buffered entry
//   in_valid/in_ready   upstream handshake (in_ready is a flop output)
//   alu_src_a [1:0]     00 PC, 01 rdata1, 10 zero-ext shamt, 11 zero
//   alu_src_b [2:0]     000 rdata2, 001 INC_CONST, 010 ext_out,
//                       011 ext_out<<2, 100 zero-ext imm16, 101 zero,
//                       11x illegal (B=0, sel_err=1)
//   pc_addr, rdata1, rdata2, ext_out, imm16, shamt   operand sources
//   a, b, sel_err       output entry (main register)
//   out_valid/out_ready downstream handshake
module alu_operand_stage #(
    parameter int WIDTH     = 32,
    parameter int INC_CONST = 4,
    parameter int SHAMT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_src_a,
    input  logic [2:0]         alu_src_b,
    input  logic [WIDTH-1:0]   pc_addr,
    input  logic [WIDTH-1:0]   rdata1,
    input  logic [WIDTH-1:0]   rdata2,
    input  logic [WIDTH-1:0]   ext_out,
    input  logic [15:0]        imm16,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               sel_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             err;
    } entry_t;

    // INC_CONST is truncated to the datapath width.
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC_CONST);

    // ------------------------------------------------------------------
    // Operand selection (combinational on the inputs)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_shamt_ext;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_ext_sl2;
    entry_t           w_sel;

    // Unsigned size casts zero-extend (or truncate if WIDTH < 16).
    assign w_shamt_ext = WIDTH'(shamt);
    assign w_imm_ext   = WIDTH'(imm16);
    // Top two bits of ext_out fall off the end.
    assign w_ext_sl2   = {ext_out[WIDTH-3:0], 2'b00};

    always_comb begin
        w_sel = '0;
        case (alu_src_a)
            2'b00:   w_sel.a = pc_addr;
            2'b01:   w_sel.a = rdata1;
            2'b10:   w_sel.a = w_shamt_ext;
            default: w_sel.a = '0;
        endcase
        case (alu_src_b)
            3'b000:  w_sel.b = rdata2;
            3'b001:  w_sel.b = INC_W;
            3'b010:  w_sel.b = ext_out;
            3'b011:  w_sel.b = w_ext_sl2;
            3'b100:  w_sel.b = w_imm_ext;
            3'b101:  w_sel.b = '0;
            default: begin
                // Illegal B select: still honour A, flag the entry.
                w_sel.b   = '0;
                w_sel.err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer: main register drives the outputs, skid catches the
    // pair that arrives while the ALU is stalled.
    // ------------------------------------------------------------------
    entry_t r_main;
    entry_t r_skid;
    logic   r_main_vld;
    logic   r_skid_vld;
    logic   r_in_ready;

    logic   w_accept;
    logic   w_pop;
    logic   w_load_main;
    logic   w_shift;
    logic   w_load_skid;
    logic   w_main_vld_nxt;
    logic   w_skid_vld_nxt;

    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_main_vld & out_ready;

    always_comb begin
        w_main_vld_nxt = r_main_vld;
        w_skid_vld_nxt = r_skid_vld;
        w_load_main    = 1'b0;
        w_shift        = 1'b0;
        w_load_skid    = 1'b0;
        if (flush) begin
            // Drop everything, including a concurrent accept; data holds.
            w_main_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
        end else if ((!r_main_vld || w_pop) && !r_skid_vld) begin
            w_load_main    = w_accept;
            w_main_vld_nxt = w_accept;
        end else if (w_pop && r_skid_vld) begin
            w_shift        = 1'b1;
            w_main_vld_nxt = 1'b1;
            w_load_skid    = w_accept;
            w_skid_vld_nxt = w_accept;
        end else if (r_main_vld && !out_ready && !r_skid_vld) begin
            w_load_skid    = w_accept;
            w_skid_vld_nxt = w_accept;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_main_vld <= w_main_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            // Registered ready: a free skid slot guarantees room for one
            // more pair whatever out_ready does next cycle.
            r_in_ready <= ~w_skid_vld_nxt;
            if (w_load_main) begin
                r_main <= w_sel;
            end else if (w_shift) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_sel;
            end
        end
    end

    assign a         = r_main.a;
    assign b         = r_main.b;
    assign sel_err   = r_main.err;
    assign out_valid = r_main_vld;
    assign in_ready  = r_in_ready;

endmodule
